// File: rtl/booth_mult_ctrl.sv
// ---------------------------------------------------------------------------
// booth_mult_ctrl
//   Sequential radix-2 Booth controller for a signed 8x8 multiply. One 8-bit
//   carry-lookahead adder is reused across 8 iterations. Operands arrive on a
//   valid/ready input handshake, and the 16-bit product leaves on a
//   valid/ready output handshake.
//
//   Ports
//     clk        in   1   rising-edge clock
//     rst        in   1   asynchronous reset, active high
//     in_valid   in   1   operand pair a/b valid
//     in_ready   out  1   controller idle and able to accept operands
//     a          in   8   multiplicand M, two's complement
//     b          in   8   multiplier Q, two's complement
//     out_valid  out  1   product p valid, held until accepted
//     out_ready  in   1   consumer accepts p
//     p          out  16  signed product a*b
//     busy       out  1   high while iterating
// ---------------------------------------------------------------------------

// carry_lookahead_adder
//   8-bit adder with generate/propagate carry lookahead.
//   Ports: a, b (8-bit addends), cin, sum (8-bit), cout.
module carry_lookahead_adder (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  // Returns the carry into each bit position (bit 8 is the carry out).
  function automatic logic [8:0] cla_carries(input logic [7:0] g,
                                             input logic [7:0] pr,
                                             input logic       c0);
    logic [8:0] c;
    c = {8'h00, c0};
    for (int i = 0; i < 8; i++) begin
      c[i+1] = g[i] | (pr[i] & c[i]);
    end
    return c;
  endfunction

  logic [7:0] gen_s;
  logic [7:0] prop_s;
  logic [8:0] carry_s;

  // Generate/propagate terms, lookahead carries and the final sum.
  always_comb begin
    gen_s   = a & b;
    prop_s  = a ^ b;
    carry_s = cla_carries(gen_s, prop_s, cin);
    sum     = prop_s ^ carry_s[7:0];
    cout    = carry_s[8];
  end

endmodule

module booth_mult_ctrl #(
  parameter int WIDTH      = 8,
  parameter int EARLY_ZERO = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_r;
  logic [7:0]  acc_r;      // Booth accumulator A
  logic [7:0]  q_r;        // multiplier / low product half Q
  logic        q_1_r;      // Booth history bit Q_-1
  logic [2:0]  cnt_r;      // iteration counter
  logic [7:0]  m_r;        // captured multiplicand M
  logic        zero_r;     // zero-operand shortcut armed for this operation
  logic [15:0] p_r;
  logic        out_valid_r;
  logic        busy_r;
  logic        in_ready_r;

  logic [7:0]  add_b_s;
  logic        add_cin_s;
  logic [7:0]  sum_s;
  logic        cout_s;
  logic        x_s;
  logic [8:0]  s9_s;
  logic [7:0]  next_acc_s;
  logic [7:0]  next_q_s;

  // Booth recoding: pick +M, -M (as ~M + 1) or 0 from the Q[0]/Q_-1 pair.
  always_comb begin
    add_b_s   = 8'h00;
    add_cin_s = 1'b0;
    case ({q_r[0], q_1_r})
      2'b01: begin
        add_b_s   = m_r;
        add_cin_s = 1'b0;
      end
      2'b10: begin
        add_b_s   = ~m_r;
        add_cin_s = 1'b1;
      end
      default: begin
        add_b_s   = 8'h00;
        add_cin_s = 1'b0;
      end
    endcase
  end

  carry_lookahead_adder u_cla (
    .a    (acc_r),
    .b    (add_b_s),
    .cin  (add_cin_s),
    .sum  (sum_s),
    .cout (cout_s)
  );

  // Reconstruct the 9th (true sign) bit of the sum so that an overflowing
  // 8-bit result (e.g. 0 - (-128)) still shifts in the correct sign.
  always_comb begin
    x_s        = acc_r[7] ^ add_b_s[7] ^ cout_s;
    s9_s       = {x_s, sum_s};
    next_acc_s = s9_s[8:1];
    next_q_s   = {s9_s[0], q_r[7:1]};
  end

  // Control FSM and datapath registers; all outputs are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      acc_r       <= 8'h00;
      q_r         <= 8'h00;
      q_1_r       <= 1'b0;
      cnt_r       <= 3'd0;
      m_r         <= 8'h00;
      zero_r      <= 1'b0;
      p_r         <= 16'h0000;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid && in_ready_r) begin
            m_r        <= a;
            q_r        <= b;
            acc_r      <= 8'h00;
            q_1_r      <= 1'b0;
            cnt_r      <= 3'd0;
            zero_r     <= (EARLY_ZERO != 0) && ((a == 8'h00) || (b == 8'h00));
            busy_r     <= 1'b1;
            in_ready_r <= 1'b0;
            state_r    <= RUN;
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          if (zero_r) begin
            // Zero operand: the product is known, spend one cycle and finish.
            p_r         <= 16'h0000;
            out_valid_r <= 1'b1;
            busy_r      <= 1'b0;
            zero_r      <= 1'b0;
            state_r     <= DONE;
          end else begin
            acc_r <= next_acc_s;
            q_r   <= next_q_s;
            q_1_r <= q_r[0];
            cnt_r <= cnt_r + 3'd1;
            if (cnt_r == 3'd7) begin
              // Capture the product from the values this final step produces.
              p_r         <= {next_acc_s, next_q_s};
              out_valid_r <= 1'b1;
              busy_r      <= 1'b0;
              state_r     <= DONE;
            end else begin
              state_r <= RUN;
            end
          end
        end
        DONE: begin
          // in_valid is deliberately ignored here; only the output side moves.
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          in_ready_r  <= 1'b1;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign p         = p_r;

endmodule

// File: tb/tb_booth_mult_ctrl.sv
// ---------------------------------------------------------------------------
// tb_booth_mult_ctrl
//   Self-checking bench for booth_mult_ctrl. A transaction-level model (one
//   outstanding product, its signed a*b value and its accept cycle) predicts
//   in_ready, busy, out_valid and p on every falling edge. Directed operations
//   also compare the delivered product against hand-computed constants.
// ---------------------------------------------------------------------------
module tb_booth_mult_ctrl;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] p;
  logic        busy;

  int checks;
  int errors;
  int cyc;
  int done_cnt;

  // model state
  bit          pending;
  logic [15:0] exp_p;
  int          t0;

  booth_mult_ctrl #(.WIDTH(8), .EARLY_ZERO(0)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cycle counter, advanced on every rising edge
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, req);
    end
  endtask

  // Compare process: on every falling edge check outputs against the model,
  // then advance the model by the handshakes that the next rising edge takes.
  initial begin
    int age;
    pending = 1'b0;
    exp_p   = 16'h0000;
    t0      = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_p", p, 16'h0000);
        chk("rst_out_valid", {15'd0, out_valid}, 16'd0);
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_in_ready", {15'd0, in_ready}, 16'd1);
        pending = 1'b0;
      end else begin
        age = cyc - t0;
        chk("in_ready", {15'd0, in_ready}, {15'd0, !pending});
        chk("busy", {15'd0, busy}, {15'd0, pending && (age < 8)});
        chk("out_valid", {15'd0, out_valid}, {15'd0, pending && (age >= 8)});
        if (pending && age >= 8) chk("p", p, exp_p);
        if (pending && age >= 8 && out_ready) begin
          pending = 1'b0;
          done_cnt++;
        end else if (!pending && in_valid && in_ready) begin
          pending = 1'b1;
          exp_p   = 16'($signed(a) * $signed(b));
          t0      = cyc + 1;
        end
      end
    end
  end

  // Offer one operand pair, wait for the product, compare it with a
  // hand-computed value, then hold out_ready low for 'stall' cycles.
  task automatic run_op(input logic [7:0] va, input logic [7:0] vb,
                        input logic [15:0] lit, input int stall, input string name);
    bit ok;
    @(posedge clk); #1;
    in_valid = 1'b1; a = va; b = vb; out_ready = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; a = $urandom; b = $urandom;
    if (!ok) begin
      errors++;
      $display("FAIL %s_accept: in_ready never seen", name);
    end
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (out_valid) ok = 1'b1;
    end
    checks++;
    if (!ok || p !== lit) begin
      errors++;
      $display("FAIL %s: got p=%h out_valid=%0b expected p=%h", name, p, out_valid, lit);
    end
    for (int i = 0; i < stall; i++) @(posedge clk);
    @(posedge clk); #1; out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
  endtask

  initial begin
    bit ok;
    int budget;
    checks = 0; errors = 0; cyc = 0; done_cnt = 0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = 8'h00; b = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    run_op(8'd3,   8'd5,   16'h000F, 0, "mul_3x5");
    run_op(8'h80,  8'h80,  16'h4000, 0, "mul_m128xm128");
    run_op(8'h80,  8'h7F,  16'hC080, 0, "mul_m128x127");
    run_op(8'hFF,  8'hFF,  16'h0001, 0, "mul_m1xm1");
    run_op(8'h7F,  8'hFF,  16'hFF81, 0, "mul_127xm1");
    run_op(8'h00,  8'h9C,  16'h0000, 0, "mul_0xneg");
    run_op(8'h0C,  8'h0A,  16'h0078, 5, "backpressure");

    // Output and input handshakes offered together in DONE: only the output
    // completes, the new operands go in on the following IDLE cycle.
    @(posedge clk); #1;
    in_valid = 1'b1; a = 8'd7; b = 8'd9;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (out_valid) ok = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (!ok || !in_ready) begin
      errors++;
      $display("FAIL simul_hs: in_ready=%0b seen_valid=%0b expected 1/1", in_ready, ok);
    end
    @(posedge clk); #1 in_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (out_valid) ok = 1'b1;
    end
    chk("simul_hs_p", p, 16'h003F);
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;

    // Reset in the middle of RUN (cnt==4): product is dropped.
    @(posedge clk); #1;
    in_valid = 1'b1; a = 8'd11; b = 8'd13;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
    end
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (12) @(posedge clk);
    run_op(8'd2, 8'hFD, 16'hFFFA, 0, "after_reset");

    // Random operands with random valid/ready stalls.
    budget = 0;
    while (done_cnt < 3007 && budget < 60000) begin
      @(posedge clk); #1;
      out_ready = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 7))
        0: a = 8'h80;
        1: a = 8'h7F;
        2: a = 8'h00;
        3: a = 8'hFF;
        default: a = 8'($urandom);
      endcase
      case ($urandom_range(0, 7))
        0: b = 8'h80;
        1: b = 8'h7F;
        2: b = 8'h00;
        3: b = 8'hFF;
        default: b = 8'($urandom);
      endcase
      in_valid = ($urandom_range(0, 2) != 0);
      budget++;
    end
    checks++;
    if (done_cnt < 3007) begin
      errors++;
      $display("FAIL random_progress: completed %0d expected 3007", done_cnt);
    end
    @(posedge clk); #1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (12) @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
